// File: rtl/uart_pkg.sv
// Shared definitions for the UART stream bridge: default widths and the TX FSM
// state encoding.
package uart_pkg;

   localparam int DATA_W_DEF   = 8;
   localparam int ADDR_W_DEF   = 4;
   localparam int TX_COUNT_W   = 16;
   localparam int DROP_COUNT_W = 8;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_WAIT  = 2'd2
   } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags. A push while
// full is accepted only when a pop frees the slot in the same cycle.
module uart_sync_fifo #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
   logic              do_push, do_pop;

   // Extra pointer MSB distinguishes a full FIFO from an empty one.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                    (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(do_pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define validity
   // and rd_data is forced to zero while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
   end

endmodule

// File: rtl/uart_stream_bridge.sv
// Valid/ready byte streams to and from the UART transmitter/receiver pulses.
// Define UART_BRIDGE_STATS_EN to add the saturating tx_count/drop_count outputs.
module uart_stream_bridge
   import uart_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic              tx_start,
   output logic [DATA_W-1:0] tx_data_out,
   input  logic              tx_busy,
   input  logic              tx_done,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_done,
   output logic              rx_overflow,
   input  logic              ovf_clear
`ifdef UART_BRIDGE_STATS_EN
   ,
   output logic [TX_COUNT_W-1:0]   tx_count,
   output logic [DROP_COUNT_W-1:0] drop_count
`endif
);

   tx_state_e         state_q;
   logic              tx_start_q;
   logic [DATA_W-1:0] tx_data_q;
   logic [DATA_W-1:0] tx_head;
   logic              tx_full, tx_empty, tx_push, tx_pop;
   logic              rx_full, rx_empty, rx_drop;
   logic              rx_ovf_q, rx_ovf_d;

   assign tx_push = s_valid & ~tx_full;
   assign tx_pop  = (state_q == TX_WAIT) & tx_done;
   // Dropped only when full and the user is not freeing a slot this cycle.
   assign rx_drop = rx_done & rx_full & ~m_ready;

   uart_sync_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (tx_push),
      .wr_data (s_data),
      .pop     (tx_pop),
      .rd_data (tx_head),
      .full    (tx_full),
      .empty   (tx_empty)
   );

   uart_sync_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (rx_done),
      .wr_data (rx_data),
      .pop     (m_ready),
      .rd_data (m_data),
      .full    (rx_full),
      .empty   (rx_empty)
   );

   assign s_ready     = ~tx_full;
   assign m_valid     = ~rx_empty;
   assign tx_start    = tx_start_q;
   assign tx_data_out = tx_data_q;
   assign rx_overflow = rx_ovf_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= TX_IDLE;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         tx_start_q <= 1'b0;
         unique case (state_q)
            TX_IDLE: begin
               if (!tx_empty && !tx_busy) begin
                  state_q    <= TX_START;
                  tx_start_q <= 1'b1;
                  tx_data_q  <= tx_head;
               end
            end
            TX_START: state_q <= TX_WAIT;
            TX_WAIT:  if (tx_done) state_q <= TX_IDLE;
            default:  state_q <= TX_IDLE;
         endcase
      end
   end

   always_comb begin
      // NOTE: each always_comb output is defaulted first so no latch is inferred.
      rx_ovf_d = rx_ovf_q;
      if (ovf_clear) rx_ovf_d = 1'b0;
      if (rx_drop)   rx_ovf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rx_ovf_q <= 1'b0;
      else     rx_ovf_q <= rx_ovf_d;
   end

`ifdef UART_BRIDGE_STATS_EN
   logic [TX_COUNT_W-1:0]   tx_count_q, tx_count_d;
   logic [DROP_COUNT_W-1:0] drop_count_q, drop_count_d;

   always_comb begin
      tx_count_d   = tx_count_q;
      drop_count_d = drop_count_q;
      if (tx_pop && (tx_count_q != '1))    tx_count_d   = tx_count_q + 1'b1;
      if (rx_drop && (drop_count_q != '1)) drop_count_d = drop_count_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_count_q   <= '0;
         drop_count_q <= '0;
      end else begin
         tx_count_q   <= tx_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign tx_count   = tx_count_q;
   assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Self-checking bench for uart_stream_bridge: a UART transmitter model plus
// queue-based reference models, exercised with directed and random traffic.
module tb_uart_stream_bridge;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int FRAME  = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              s_valid = 1'b0;
   logic [DATA_W-1:0] s_data = '0;
   logic              s_ready;
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_ready = 1'b0;
   logic              tx_start;
   logic [DATA_W-1:0] tx_data_out;
   logic              tx_busy;
   logic              tx_done;
   logic [DATA_W-1:0] rx_data = '0;
   logic              rx_done = 1'b0;
   logic              rx_overflow;
   logic              ovf_clear = 1'b0;
`ifdef UART_BRIDGE_STATS_EN
   logic [15:0]       tx_count;
   logic [7:0]        drop_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // UART transmitter model state
   int          cyc = 0;
   int          busy_cnt = 0;
   int          last_done_cyc = 0;
   bit          uart_hold = 1'b0;
   bit          b2b_check = 1'b0;
   logic [7:0]  frame_byte = '0;
   logic [7:0]  tx_seen[$];

   uart_stream_bridge dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_ready     (s_ready),
      .m_valid     (m_valid),
      .m_data      (m_data),
      .m_ready     (m_ready),
      .tx_start    (tx_start),
      .tx_data_out (tx_data_out),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .rx_data     (rx_data),
      .rx_done     (rx_done),
      .rx_overflow (rx_overflow),
      .ovf_clear   (ovf_clear)
`ifdef UART_BRIDGE_STATS_EN
      ,
      .tx_count    (tx_count),
      .drop_count  (drop_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter: takes tx_data_out on tx_start, busy for FRAME cycles, then tx_done.
   initial begin
      tx_busy = 1'b0;
      tx_done = 1'b0;
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (rst) begin
            busy_cnt = 0;
            tx_busy  = uart_hold;
         end else if (busy_cnt > 0) begin
            n_checks++;
            if (tx_start !== 1'b0 || tx_data_out !== frame_byte) begin
               n_fail++;
               $display("FAIL tx_frame_hold: tx_start=%b data=%h, required tx_start=0 data=%h",
                        tx_start, tx_data_out, frame_byte);
            end
            busy_cnt--;
            if (busy_cnt == 0) begin
               tx_done       = 1'b1;
               tx_busy       = uart_hold;
               last_done_cyc = cyc;
            end
         end else begin
            tx_busy = uart_hold;
            if (tx_start === 1'b1) begin
               if (b2b_check && tx_seen.size() > 0) begin
                  n_checks++;
                  if (cyc - last_done_cyc != 2) begin
                     n_fail++;
                     $display("FAIL tx_restart_gap: %0d cycles after tx_done, required 2",
                              cyc - last_done_cyc);
                  end
               end
               frame_byte = tx_data_out;
               tx_seen.push_back(tx_data_out);
               busy_cnt = FRAME;
               tx_busy  = 1'b1;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      s_valid   = 1'b0;
      m_ready   = 1'b0;
      rx_done   = 1'b0;
      ovf_clear = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      uart_hold = 1'b0;
      b2b_check = 1'b0;
      step();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      tx_seen.delete();
   endtask

   task automatic test_reset();
      int k;
      idle_inputs();
      repeat (3) step();
      n_checks++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_streams: s_ready=%b m_valid=%b m_data=%h, required 1 0 00",
                  s_ready, m_valid, m_data);
      end
      n_checks++;
      if (tx_start !== 1'b0 || tx_data_out !== 8'h00 || rx_overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_tx: tx_start=%b tx_data_out=%h rx_overflow=%b, required 0 00 0",
                  tx_start, tx_data_out, rx_overflow);
      end
`ifdef UART_BRIDGE_STATS_EN
      n_checks++;
      if (tx_count !== 16'd0 || drop_count !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_stats: tx_count=%0d drop_count=%0d, required 0 0", tx_count, drop_count);
      end
`endif
      rst = 1'b0;
      // Build up state: overflowing RX FIFO, then a TX frame in flight.
      for (int i = 0; i < DEPTH + 1; i++) begin
         step();
         rx_done = 1'b1;
         rx_data = 8'($urandom);
      end
      step();
      rx_done = 1'b0;
      s_valid = 1'b1;
      s_data  = 8'h3C;
      step();
      s_valid = 1'b0;
      k = 0;
      while (tx_start !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      n_checks++;
      if (tx_start !== 1'b1 || rx_overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_precondition: tx_start=%b rx_overflow=%b, required 1 1", tx_start, rx_overflow);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (tx_start !== 1'b0 || tx_data_out !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_mid_tx: tx_start=%b tx_data_out=%h, required 0 00", tx_start, tx_data_out);
      end
      n_checks++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0 || rx_overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_flags: s_ready=%b m_valid=%b rx_overflow=%b, required 1 0 0",
                  s_ready, m_valid, rx_overflow);
      end
      step();
      step();
      rst = 1'b0;
      tx_seen.delete();
   endtask

   task automatic test_single_tx();
      int k, start_cyc;
      do_reset();
      step();
      s_valid = 1'b1;
      s_data  = 8'hA5;
      step();
      s_valid = 1'b0;
      k = 1;
      while (tx_start !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      start_cyc = cyc;
      n_checks++;
      if (tx_start !== 1'b1 || k != 2) begin
         n_fail++;
         $display("FAIL single_latency: tx_start after %0d cycles, required 2", k);
      end
      n_checks++;
      if (tx_data_out !== 8'hA5) begin
         n_fail++;
         $display("FAIL single_data: tx_data_out=%h, required a5", tx_data_out);
      end
      repeat (FRAME + 6) step();
      n_checks++;
      if (tx_seen.size() != 1 || last_done_cyc - start_cyc != FRAME) begin
         n_fail++;
         $display("FAIL single_frame: %0d starts, done after %0d cycles, required 1 start, done after %0d",
                  tx_seen.size(), last_done_cyc - start_cyc, FRAME);
      end
      n_checks++;
      if (s_ready !== 1'b1 || tx_start !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle: s_ready=%b tx_start=%b, required 1 0", s_ready, tx_start);
      end
   endtask

   task automatic test_tx_burst();
      int n_acc, guard;
      do_reset();
      uart_hold = 1'b1;
      b2b_check = 1'b1;
      n_acc = 0;
      guard = 0;
      while (n_acc < DEPTH && guard < 40) begin
         step();
         s_valid = 1'b1;
         s_data  = 8'(n_acc);
         if (s_ready) n_acc++;
         guard++;
      end
      step();
      s_data = 8'(DEPTH);
      n_checks++;
      if (s_ready !== 1'b0 || n_acc != DEPTH) begin
         n_fail++;
         $display("FAIL burst_full: s_ready=%b after %0d pushes, required 0 after %0d", s_ready, n_acc, DEPTH);
      end
      repeat (4) step();
      n_checks++;
      if (tx_seen.size() != 0) begin
         n_fail++;
         $display("FAIL burst_busy_gate: %0d starts while tx_busy held, required 0", tx_seen.size());
      end
      uart_hold = 1'b0;
      guard = 0;
      while (s_ready !== 1'b1 && guard < 100) begin
         step();
         guard++;
      end
      step();
      s_valid = 1'b0;
      guard = 0;
      while (tx_seen.size() < DEPTH + 1 && guard < (DEPTH + 1) * (FRAME + 3) + 40) begin
         step();
         guard++;
      end
      repeat (FRAME + 6) step();
      n_checks++;
      if (tx_seen.size() != DEPTH + 1) begin
         n_fail++;
         $display("FAIL burst_count: %0d tx_start pulses, required %0d", tx_seen.size(), DEPTH + 1);
      end
      for (int i = 0; i < tx_seen.size(); i++) begin
         n_checks++;
         if (tx_seen[i] !== 8'(i)) begin
            n_fail++;
            $display("FAIL burst_order[%0d]: %h, required %h", i, tx_seen[i], 8'(i));
         end
      end
      b2b_check = 1'b0;
   endtask

   task automatic test_rx_fill();
      logic [7:0] b[DEPTH+1];
      do_reset();
      foreach (b[i]) b[i] = 8'($urandom);
      for (int i = 0; i < DEPTH + 1; i++) begin
         step();
         rx_done = 1'b1;
         rx_data = b[i];
         if (i == 1) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== b[0]) begin
               n_fail++;
               $display("FAIL rx_latency: m_valid=%b m_data=%h, required 1 %h", m_valid, m_data, b[0]);
            end
         end
      end
      step();
      rx_done = 1'b0;
      n_checks++;
      if (rx_overflow !== 1'b1 || m_data !== b[0]) begin
         n_fail++;
         $display("FAIL rx_overflow_set: rx_overflow=%b m_data=%h, required 1 %h", rx_overflow, m_data, b[0]);
      end
      for (int i = 0; i < DEPTH; i++) begin
         n_checks++;
         if (m_valid !== 1'b1 || m_data !== b[i]) begin
            n_fail++;
            $display("FAIL rx_pop[%0d]: m_valid=%b m_data=%h, required 1 %h", i, m_valid, m_data, b[i]);
         end
         m_ready = 1'b1;
         step();
      end
      m_ready = 1'b0;
      n_checks++;
      if (m_valid !== 1'b0 || m_data !== 8'h00 || rx_overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL rx_drained: m_valid=%b m_data=%h rx_overflow=%b, required 0 00 1",
                  m_valid, m_data, rx_overflow);
      end
   endtask

   task automatic test_rx_boundary();
      logic [7:0] b[DEPTH];
      logic [7:0] x, y;
      do_reset();
      foreach (b[i]) b[i] = 8'($urandom);
      x = 8'($urandom);
      y = 8'($urandom);
      for (int i = 0; i < DEPTH; i++) begin
         step();
         rx_done = 1'b1;
         rx_data = b[i];
      end
      step();
      rx_data = x;
      m_ready = 1'b1;
      step();
      rx_done = 1'b0;
      m_ready = 1'b0;
      n_checks++;
      if (rx_overflow !== 1'b0 || m_data !== b[1]) begin
         n_fail++;
         $display("FAIL rx_full_push_pop: rx_overflow=%b m_data=%h, required 0 %h", rx_overflow, m_data, b[1]);
      end
      rx_done   = 1'b1;
      rx_data   = y;
      ovf_clear = 1'b1;
      step();
      rx_done   = 1'b0;
      n_checks++;
      if (rx_overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL rx_set_wins: rx_overflow=%b, required 1", rx_overflow);
      end
      step();
      ovf_clear = 1'b0;
      n_checks++;
      if (rx_overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL rx_clear: rx_overflow=%b, required 0", rx_overflow);
      end
      for (int i = 1; i <= DEPTH; i++) begin
         n_checks++;
         if (m_valid !== 1'b1 || m_data !== ((i == DEPTH) ? x : b[i])) begin
            n_fail++;
            $display("FAIL rx_boundary_pop[%0d]: m_valid=%b m_data=%h, required 1 %h",
                     i, m_valid, m_data, (i == DEPTH) ? x : b[i]);
         end
         m_ready = 1'b1;
         step();
      end
      m_ready = 1'b0;
      n_checks++;
      if (m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rx_boundary_empty: m_valid=%b, required 0", m_valid);
      end
   endtask

   task automatic test_random();
      logic [7:0] rx_q[$];
      logic [7:0] tx_exp[$];
      logic [7:0] head;
      logic       ovf_exp;
      bit         pop, drop;
      int         guard;
      do_reset();
      ovf_exp = 1'b0;
      for (int c = 0; c < 400; c++) begin
         step();
         head = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
         n_checks++;
         if (m_valid !== (rx_q.size() > 0) || m_data !== head) begin
            n_fail++;
            $display("FAIL rand_rx[%0d]: m_valid=%b m_data=%h, required %b %h",
                     c, m_valid, m_data, rx_q.size() > 0, head);
         end
         n_checks++;
         if (rx_overflow !== ovf_exp) begin
            n_fail++;
            $display("FAIL rand_ovf[%0d]: rx_overflow=%b, required %b", c, rx_overflow, ovf_exp);
         end
         rx_done   = 1'($urandom_range(0, 1));
         rx_data   = 8'($urandom);
         m_ready   = ($urandom_range(0, 2) == 0);
         ovf_clear = ($urandom_range(0, 15) == 0);
         s_valid   = 1'($urandom_range(0, 1));
         s_data    = 8'($urandom);
         if (s_valid && s_ready) tx_exp.push_back(s_data);
         pop  = m_ready && (rx_q.size() > 0);
         drop = rx_done && (rx_q.size() == DEPTH) && !pop;
         if (pop) void'(rx_q.pop_front());
         if (rx_done && !drop) rx_q.push_back(rx_data);
         ovf_exp = drop || (ovf_exp && !ovf_clear);
      end
      step();
      idle_inputs();
      guard = 0;
      while (tx_seen.size() < tx_exp.size() && guard < (DEPTH + 2) * (FRAME + 3) + 40) begin
         step();
         guard++;
      end
      repeat (FRAME + 6) step();
      n_checks++;
      if (tx_seen.size() != tx_exp.size()) begin
         n_fail++;
         $display("FAIL rand_tx_count: %0d frames, required %0d", tx_seen.size(), tx_exp.size());
      end
      for (int i = 0; i < tx_exp.size() && i < tx_seen.size(); i++) begin
         n_checks++;
         if (tx_seen[i] !== tx_exp[i]) begin
            n_fail++;
            $display("FAIL rand_tx[%0d]: %h, required %h", i, tx_seen[i], tx_exp[i]);
         end
      end
   endtask

`ifdef UART_BRIDGE_STATS_EN
   task automatic test_stats();
      int guard;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         s_valid = 1'b1;
         s_data  = 8'(8'h50 + i);
      end
      step();
      s_valid = 1'b0;
      guard = 0;
      while (tx_seen.size() < 3 && guard < 80) begin
         step();
         guard++;
      end
      repeat (FRAME + 6) step();
      for (int i = 0; i < DEPTH + 2; i++) begin
         step();
         rx_done = 1'b1;
         rx_data = 8'($urandom);
      end
      step();
      rx_done = 1'b0;
      n_checks++;
      if (tx_count !== 16'd3 || drop_count !== 8'd2 || rx_overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL stats_counts: tx_count=%0d drop_count=%0d rx_overflow=%b, required 3 2 1",
                  tx_count, drop_count, rx_overflow);
      end
      ovf_clear = 1'b1;
      step();
      ovf_clear = 1'b0;
      n_checks++;
      if (rx_overflow !== 1'b0 || drop_count !== 8'd2) begin
         n_fail++;
         $display("FAIL stats_clear: rx_overflow=%b drop_count=%0d, required 0 2", rx_overflow, drop_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_tx();
      test_tx_burst();
      test_rx_fill();
      test_rx_boundary();
      test_random();
`ifdef UART_BRIDGE_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
